// File: rtl/our_header_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : our_header_tx_if
// Purpose  : Request, RAM-read and stream signals of the header transmitter.
// Revision : 1.0
// ============================================================================
interface our_header_tx_if #(
    parameter int PAY_LEN_W = 8
);
    logic                 start;
    logic                 type_sel;
    logic [23:0]          flag_lo;
    logic [PAY_LEN_W-1:0] pay_len;
    logic                 ram_rd;
    logic [PAY_LEN_W-1:0] ram_addr;
    logic [7:0]           ram_q;
    logic [7:0]           dataout;
    logic                 ena_out;
    logic                 busy;
    logic                 done;

    modport master (
        output start, type_sel, flag_lo, pay_len, ram_q,
        input  ram_rd, ram_addr, dataout, ena_out, busy, done
    );

    modport slave (
        input  start, type_sel, flag_lo, pay_len, ram_q,
        output ram_rd, ram_addr, dataout, ena_out, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/our_header_tx.sv
`default_nettype none
// ============================================================================
// Module   : our_header_tx
// Purpose  : Emits a 4-byte type/flag header then a RAM payload as one burst.
// Revision : 1.0
// ============================================================================
module our_header_tx #(
    parameter int PAY_LEN_W = 8
) (
    input  wire logic      clock,
    input  wire logic      sclr_n,
    our_header_tx_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_PAY  = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [1:0]           r_hdr_idx, w_hdr_idx_nxt;
    logic [PAY_LEN_W-1:0] r_pay_cnt, w_pay_cnt_nxt;

    logic                 r_type_sel;
    logic [23:0]          r_flag_lo;
    logic [PAY_LEN_W-1:0] r_pay_len;
    logic [PAY_LEN_W-1:0] w_last;

    logic [7:0]           r_dataout, w_dataout_nxt;
    logic                 r_ena_out, w_ena_out_nxt;
    logic                 r_busy, w_busy_nxt;
    logic                 r_done, w_done_nxt;
    logic                 r_ram_rd, w_ram_rd_nxt;
    logic [PAY_LEN_W-1:0] r_ram_addr, w_ram_addr_nxt;

    assign w_last = r_pay_len - PAY_LEN_W'(1);

    always_ff @(posedge clock) begin
        if (!sclr_n) begin
            r_state    <= S_IDLE;
            r_hdr_idx  <= 2'd0;
            r_pay_cnt  <= '0;
            r_type_sel <= 1'b0;
            r_flag_lo  <= '0;
            r_pay_len  <= '0;
            r_dataout  <= '0;
            r_ena_out  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_ram_rd   <= 1'b0;
            r_ram_addr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_hdr_idx  <= w_hdr_idx_nxt;
            r_pay_cnt  <= w_pay_cnt_nxt;
            r_dataout  <= w_dataout_nxt;
            r_ena_out  <= w_ena_out_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_ram_rd   <= w_ram_rd_nxt;
            r_ram_addr <= w_ram_addr_nxt;
            if (r_state == S_IDLE && bus.start) begin
                r_type_sel <= bus.type_sel;
                r_flag_lo  <= bus.flag_lo;
                r_pay_len  <= bus.pay_len;
            end
        end
    end

    // Outputs are registered, so each branch computes what the next cycle shows.
    always_comb begin
        w_state_nxt   = r_state;
        w_hdr_idx_nxt = r_hdr_idx;
        w_pay_cnt_nxt = r_pay_cnt;
        w_dataout_nxt = 8'h00;
        w_ena_out_nxt = 1'b0;
        w_busy_nxt    = 1'b0;
        w_done_nxt    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt   = S_HDR;
                    w_hdr_idx_nxt = 2'd0;
                    w_dataout_nxt = {7'b0, bus.type_sel};
                    w_ena_out_nxt = 1'b1;
                    w_busy_nxt    = 1'b1;
                end
            end
            S_HDR: begin
                w_busy_nxt    = 1'b1;
                w_ena_out_nxt = 1'b1;
                w_hdr_idx_nxt = r_hdr_idx + 2'd1;
                case (r_hdr_idx)
                    2'd0:    w_dataout_nxt = r_flag_lo[23:16];
                    2'd1:    w_dataout_nxt = r_flag_lo[15:8];
                    2'd2:    w_dataout_nxt = r_flag_lo[7:0];
                    default: begin
                        w_hdr_idx_nxt = 2'd0;
                        if (r_pay_len != '0) begin
                            w_state_nxt   = S_PAY;
                            w_pay_cnt_nxt = '0;
                            w_dataout_nxt = bus.ram_q;
                        end else begin
                            w_state_nxt   = S_GAP;
                            w_ena_out_nxt = 1'b0;
                            w_done_nxt    = 1'b1;
                        end
                    end
                endcase
            end
            S_PAY: begin
                w_busy_nxt = 1'b1;
                if (r_pay_cnt == w_last) begin
                    w_state_nxt = S_GAP;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_pay_cnt_nxt = r_pay_cnt + PAY_LEN_W'(1);
                    w_dataout_nxt = bus.ram_q;
                    w_ena_out_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Reads run two cycles ahead of the byte they feed, stopping at the last address.
    always_comb begin
        w_ram_rd_nxt   = 1'b0;
        w_ram_addr_nxt = '0;
        if (r_state == S_HDR && r_hdr_idx == 2'd1 && r_pay_len != '0) begin
            w_ram_rd_nxt = 1'b1;
        end else if (r_ram_rd && r_ram_addr != w_last) begin
            w_ram_rd_nxt   = 1'b1;
            w_ram_addr_nxt = r_ram_addr + PAY_LEN_W'(1);
        end
    end

    assign bus.dataout  = r_dataout;
    assign bus.ena_out  = r_ena_out;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.ram_rd   = r_ram_rd;
    assign bus.ram_addr = r_ram_addr;
endmodule
`default_nettype wire

// File: tb/tb_our_header_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_our_header_tx
// Purpose  : Randomized self-checking bench for our_header_tx.
// Revision : 1.0
// ============================================================================
module tb_our_header_tx;
    localparam int PW = 8;

    logic clock = 1'b0;
    logic sclr_n;

    our_header_tx_if #(.PAY_LEN_W(PW)) bus ();

    our_header_tx #(.PAY_LEN_W(PW)) dut (
        .clock  (clock),
        .sclr_n (sclr_n),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    // Synchronous RAM: data one cycle after the read, garbage otherwise.
    logic [7:0] mem [256];
    always @(posedge clock) begin
        if (bus.ram_rd) bus.ram_q <= mem[bus.ram_addr];
        else            bus.ram_q <= 8'($urandom);
    end

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, ".ena_out"},  32'(bus.ena_out),  32'd0);
        chk({tag, ".dataout"},  32'(bus.dataout),  32'd0);
        chk({tag, ".busy"},     32'(bus.busy),     32'd0);
        chk({tag, ".done"},     32'(bus.done),     32'd0);
        chk({tag, ".ram_rd"},   32'(bus.ram_rd),   32'd0);
        chk({tag, ".ram_addr"}, 32'(bus.ram_addr), 32'd0);
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic pkt(input bit ts, input logic [23:0] fl, input int len,
                       input bit keep, input int abort_at);
        logic [7:0] hdr [4];
        logic [7:0] e_d;
        bit         e_ena, e_busy, e_done, e_rd;
        int         e_addr;
        hdr[0] = {7'b0, ts};
        hdr[1] = fl[23:16];
        hdr[2] = fl[15:8];
        hdr[3] = fl[7:0];
        bus.start    = 1'b1;
        bus.type_sel = ts;
        bus.flag_lo  = fl;
        bus.pay_len  = PW'(len);
        for (int j = 1; j <= 6 + len; j++) begin
            @(negedge clock);
            if (abort_at > 0 && j == abort_at + 1) begin
                check_idle($sformatf("abort@%0d", j));
                @(negedge clock);
                check_idle("abort_hold");
                sclr_n    = 1'b1;
                bus.start = 1'b0;
                @(negedge clock);
                check_idle("abort_release");
                return;
            end
            e_ena  = (j >= 1 && j <= 4 + len);
            e_busy = (j >= 1 && j <= 5 + len);
            e_done = (j == 5 + len);
            e_rd   = (j >= 3 && j <= 2 + len);
            e_addr = e_rd ? j - 3 : 0;
            if (j <= 4)            e_d = hdr[j-1];
            else if (j <= 4 + len) e_d = mem[j-5];
            else                   e_d = 8'h00;
            chk($sformatf("ena_out@%0d", j),  32'(bus.ena_out),  32'(e_ena));
            chk($sformatf("dataout@%0d", j),  32'(bus.dataout),  32'(e_d));
            chk($sformatf("busy@%0d", j),     32'(bus.busy),     32'(e_busy));
            chk($sformatf("done@%0d", j),     32'(bus.done),     32'(e_done));
            chk($sformatf("ram_rd@%0d", j),   32'(bus.ram_rd),   32'(e_rd));
            chk($sformatf("ram_addr@%0d", j), 32'(bus.ram_addr), 32'(e_addr));
            if (abort_at > 0 && j == abort_at) sclr_n = 1'b0;
            if (j <= 4 + len) begin
                bus.type_sel = 1'($urandom);
                bus.flag_lo  = 24'($urandom);
                bus.pay_len  = PW'($urandom);
                bus.start    = keep ? 1'b1 : 1'($urandom);
            end else begin
                bus.start = keep;
            end
        end
        if (!keep) bus.start = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        sclr_n       = 1'b0;
        bus.start    = 1'b1;
        bus.type_sel = 1'b0;
        bus.flag_lo  = '0;
        bus.pay_len  = '0;
        repeat (3) begin
            @(negedge clock);
            check_idle("reset");
        end
        sclr_n    = 1'b1;
        bus.start = 1'b0;
        @(negedge clock);
        check_idle("post_reset");

        pkt(1'b0, 24'hA1B2C3, 0, 1'b0, 0);

        mem[0] = 8'h11;
        mem[1] = 8'h22;
        mem[2] = 8'h33;
        pkt(1'b1, 24'h000102, 3, 1'b0, 0);

        repeat (3) pkt(1'($urandom), 24'($urandom), 1, 1'b1, 0);
        pkt(1'($urandom), 24'($urandom), 1, 1'b0, 0);

        repeat (8) pkt(1'($urandom), 24'($urandom), int'($urandom_range(0, 20)), 1'b0, 0);

        pkt(1'b0, 24'($urandom), 255, 1'b0, 0);
        pkt(1'b1, 24'($urandom), 255, 1'b0, 50);
        pkt(1'b0, 24'($urandom), 5, 1'b0, 0);

        @(negedge clock);
        check_idle("final");
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
